scheduler_sched_info_table: RTL

Per-accelerator-type schedule info table for the OmpSs@FPGA scheduler. It generalises the single-read, unresettable schedule-data RAM in four ways: parametrised word width, N parallel read ports, per-entry valid bits, and write-first forwarding. It also holds a per-type round-robin pointer that the scheduler uses to pick the next accelerator instance of a type. It sits between the command-in/spawn logic, which writes the table, and the scheduler dispatch stages, which read it.

---
 rtl/scheduler_sched_info_table.sv | 105 ++++++++++
 1 files changed

// File: rtl/scheduler_sched_info_table.sv
// Per-accelerator-type schedule info table: multi-port reads with write-first
// forwarding, per-entry valid bits and a per-type round-robin instance pointer.
module scheduler_sched_info_table #(
  parameter int MAX_ACC_TYPES = 16,
  parameter int ACC_TYPE_BITS = $clog2(MAX_ACC_TYPES),
  parameter int DATA_BITS     = 48,
  parameter int NUM_RD_PORTS  = 2,
  parameter int CNT_BITS      = 8
) (
  input  logic                                clk,
  input  logic                                rstn,
  input  logic                                flush,
  input  logic                                wr_en,
  input  logic                                wr_clear,
  input  logic [ACC_TYPE_BITS-1:0]            wr_addr,
  input  logic [DATA_BITS-1:0]                wr_data,
  input  logic [NUM_RD_PORTS-1:0]             rd_en,
  input  logic [NUM_RD_PORTS*ACC_TYPE_BITS-1:0] rd_addr,
  output logic [NUM_RD_PORTS-1:0]             rd_valid,
  output logic [NUM_RD_PORTS-1:0]             rd_hit,
  output logic [NUM_RD_PORTS*DATA_BITS-1:0]   rd_data,
  input  logic                                rr_req,
  input  logic [ACC_TYPE_BITS-1:0]            rr_addr,
  output logic                                rr_valid,
  output logic                                rr_hit,
  output logic [CNT_BITS-1:0]                 rr_idx
);

  logic [MAX_ACC_TYPES-1:0][DATA_BITS-1:0] r_mem;
  logic [MAX_ACC_TYPES-1:0]                r_valid;
  logic [MAX_ACC_TYPES-1:0][CNT_BITS-1:0]  r_rr_ptr;

  logic w_wr_upd, w_wr_set;
  assign w_wr_upd = wr_en & ~flush;
  assign w_wr_set = w_wr_upd & ~wr_clear;

  // Read ports see the post-update state of their entry (write-first).
  logic [NUM_RD_PORTS-1:0]                w_rd_hit;
  logic [NUM_RD_PORTS-1:0][DATA_BITS-1:0] w_rd_dat;

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic [ACC_TYPE_BITS-1:0] w_ra;
    assign w_ra        = rd_addr[p*ACC_TYPE_BITS +: ACC_TYPE_BITS];
    assign w_rd_hit[p] = flush ? 1'b0 :
                         (w_wr_upd && wr_addr == w_ra) ? ~wr_clear : r_valid[w_ra];
    assign w_rd_dat[p] = (w_wr_set && wr_addr == w_ra) ? wr_data : r_mem[w_ra];
  end

  logic                w_rr_fwd, w_rr_vld, w_rr_ok, w_rr_oob;
  logic [CNT_BITS-1:0] w_rr_cnt, w_rr_ptr, w_rr_idx, w_rr_inc, w_rr_nxt;

  assign w_rr_fwd = w_wr_upd && (wr_addr == rr_addr);
  assign w_rr_vld = flush ? 1'b0 : w_rr_fwd ? ~wr_clear : r_valid[rr_addr];
  assign w_rr_cnt = (w_wr_set && wr_addr == rr_addr) ? wr_data[CNT_BITS-1:0]
                                                     : r_mem[rr_addr][CNT_BITS-1:0];
  assign w_rr_ptr = (flush || w_rr_fwd) ? '0 : r_rr_ptr[rr_addr];
  assign w_rr_ok  = rr_req && w_rr_vld && (w_rr_cnt != '0);
  // An out-of-range pointer is treated as 0, so the next pointer is 1 mod cnt.
  assign w_rr_oob = (w_rr_ptr >= w_rr_cnt);
  assign w_rr_idx = w_rr_oob ? '0 : w_rr_ptr;
  assign w_rr_inc = w_rr_idx + CNT_BITS'(1);
  assign w_rr_nxt = (w_rr_inc == w_rr_cnt) ? '0 : w_rr_inc;

  always_ff @(posedge clk) begin
    if (w_wr_set) r_mem[wr_addr] <= wr_data;
  end

  // The pick increment is assigned last so it overrides a same-cycle write's reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
    end else if (flush) begin
      r_valid  <= '0;
      r_rr_ptr <= '0;
    end else begin
      if (wr_en) begin
        r_valid[wr_addr]  <= ~wr_clear;
        r_rr_ptr[wr_addr] <= '0;
      end
      if (w_rr_ok) r_rr_ptr[rr_addr] <= w_rr_nxt;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_valid <= '0;
      rd_hit   <= '0;
      rd_data  <= '0;
      rr_valid <= 1'b0;
      rr_hit   <= 1'b0;
      rr_idx   <= '0;
    end else begin
      rd_valid <= rd_en;
      rd_hit   <= rd_en & w_rd_hit;
      for (int p = 0; p < NUM_RD_PORTS; p++) begin
        if (rd_en[p]) rd_data[p*DATA_BITS +: DATA_BITS] <= w_rd_hit[p] ? w_rd_dat[p] : '0;
      end
      rr_valid <= rr_req;
      rr_hit   <= w_rr_ok;
      rr_idx   <= w_rr_ok ? w_rr_idx : '0;
    end
  end

endmodule
